weight_fifo_reader: RTL

WEIGHT_FIFO_READER -- requirements
Module: weight_fifo_reader

---
 rtl/weight_fifo_reader.sv | 79 +++++++
 1 files changed

// File: rtl/weight_fifo_reader.sv
// Drains one tile of N_WEIGHTS signed weights from a registered-read FIFO
// and presents them to a PE column, with abort, stall and busy-start handling.
module weight_fifo_reader #(
  parameter int N_WEIGHTS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               fifo_empty,
  input  logic signed [15:0] fifo_rdata,
  output logic               fifo_rd_en,
  output logic signed [15:0] w_out,
  output logic               w_valid,
  output logic               tile_done,
  output logic               busy,
  output logic               start_err
);

  localparam int CW = $clog2(N_WEIGHTS + 1);
  localparam logic [CW-1:0] N_FULL = CW'(N_WEIGHTS);
  localparam logic [CW-1:0] N_LAST = CW'(N_WEIGHTS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] issued_cnt, recv_cnt;
  logic          rd_pend;
  logic          last_issue;
  logic          last_recv;

  assign busy = (state != IDLE);

  // Handshake: a pop is issued only when the FIFO is non-empty; the popped
  // word appears on fifo_rdata one cycle later (rd_pend marks that cycle) and
  // is registered onto w_out/w_valid the cycle after that.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = (state == READ) && !fifo_empty && (issued_cnt < N_FULL) && !abort;
    last_issue = fifo_rd_en && (issued_cnt == N_LAST);
    last_recv  = (state == DRAIN) && rd_pend && (recv_cnt == N_LAST) && !abort;
    case (state)
      IDLE:    if (start)      state_nxt = READ;
      READ:    if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_recv)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issued_cnt <= '0;
      recv_cnt   <= '0;
      rd_pend    <= 1'b0;
      w_out      <= '0;
      w_valid    <= 1'b0;
      tile_done  <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_pend   <= fifo_rd_en;
      w_valid   <= rd_pend && !abort;
      tile_done <= last_recv;
      if (rd_pend && !abort) w_out <= fifo_rdata;
      if (start && busy) start_err <= 1'b1;
      // Abort drops the in-flight word, so its counters restart from zero.
      if (abort || (state == IDLE && start)) begin
        issued_cnt <= '0;
        recv_cnt   <= '0;
      end else begin
        if (fifo_rd_en) issued_cnt <= issued_cnt + CW'(1);
        if (rd_pend)    recv_cnt   <= recv_cnt + CW'(1);
      end
    end
  end

endmodule
